or1200_enc_store_xor: RTL and testbench
=======================================

# or1200_enc_store_xor

Store-path encryption unit for the OR1200 data side. It takes a store from the LSU and waits for the store encryption FSM to deliver a valid 128-bit pad. It then selects and byte-aligns the 32-bit pad word for the target address, XORs it onto the store data, and issues the encrypted write to the data cache. The pipeline stays stalled until the cache acknowledges. It is the write-side counterpart of the load-path pad shifter and sits between the LSU store port and the dcache write port.

## Interface
Parameters:
- PAD_W, 128, encryption pad width; must be 4*DW.
- DW, 32, data/address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- st_req_i  in  1  store request from LSU. Held until store_stall_o falls.
- st_op_i  in  4  LSU op; OR1200_LSUOP_SB/SH/SW.
- st_adr_i  in  DW  byte address.
- st_dat_i  in  DW  lane-aligned store data.
- st_sel_i  in  4  byte enables; bit 3 = bits [31:24].
- pad_valid_i  in  1  store pad ready (enc_done/unstall of the store FSM).
- pad_i  in  PAD_W  store pad; word k = pad_i[32k+31:32k].
- dc_ack_i  in  1  dcache write acknowledge.
- dc_req_o  out  1  dcache write request.
- dc_adr_o  out  DW  registered address.
- dc_dat_o  out  DW  encrypted data.
- dc_sel_o  out  4  byte enables.
- pad_consume_o  out  1  one-cycle pulse; pad used, FSM may regenerate.
- store_stall_o  out  1  pipeline stall.
- err_o  out  1  one-cycle pulse on misaligned store.

## Operation
States: IDLE, WAIT_PAD, XOR, ISSUE.
- IDLE + st_req_i: latch op, adr, dat, sel.
  - Misaligned (SH with adr[0]=1, or SW with adr[1:0]≠0): pulse err_o next cycle and stay in IDLE.
  - Otherwise go to XOR if pad_valid_i=1, else WAIT_PAD.
- WAIT_PAD: hold until pad_valid_i=1, then go to XOR.
- XOR: register the encrypted data, then go to ISSUE.
  - Pad word w = pad_i word adr[3:2].
  - Rotate w right by 8*adr[1:0].
  - dc_dat_o byte i = st_dat byte i ^ rotated-pad byte i if sel[i], else st_dat byte i.
- ISSUE: dc_req_o=1 with adr/dat/sel stable. On dc_ack_i, pulse pad_consume_o and go to IDLE.
- store_stall_o = (IDLE & st_req_i) | (state≠IDLE & !(ISSUE & dc_ack_i)).
- st_req_i while not IDLE is ignored; the stall forces the LSU to hold it.
- pad_valid_i dropping after the XOR state has no effect.

## Timing
- Reset values: all outputs 0; state IDLE; latched registers 0.
- Reset mid-operation clears every output asynchronously. The operation is discarded with no pad_consume_o.
- Minimum latency with pad ready: request at cycle 0, XOR at cycle 1, dc_req_o high at cycle 2. With same-cycle ack, store_stall_o is low at cycle 2.
- dc_req_o rises exactly one cycle after XOR and stays high until the ack cycle inclusive.
- pad_consume_o and the falling edge of store_stall_o coincide with the dc_ack_i cycle.
- dc_ack_i outside ISSUE is ignored.
- A back-to-back request may be accepted in the cycle after the ack.

## Structure
- LSU op encodings come from or1200_defines.v.
- Local constants: state encodings (2-bit); constant PAD_WORDS = PAD_W/DW.
- Sub-module or1200_enc_pad_align: combinational pad word select plus byte rotate. Takes pad, adr[3:0]; returns 32-bit aligned pad.
- Top contains the FSM, latches and stall logic; target 150-250 lines total.

## Test plan
Pad 128'h0123456789abcdef0123456789abcdef (words 0..3 = 89abcdef, 01234567, 89abcdef, 01234567).
- SW adr 0x100, dat 0xdeadbeef, sel 4'hf, pad valid -> cycle 2: dc_req_o=1, dc_dat_o=0x57067300, dc_adr_o=0x100.
- SB adr 0x105, dat 0x00ab0000, sel 4'b0100 -> rotated pad 0x67012345; dc_dat_o=0x00aa0000, dc_sel_o=4'b0100.
- SW with pad_valid_i low for 5 cycles -> stays in WAIT_PAD, store_stall_o=1, dc_req_o=0; dc_req_o rises 2 cycles after pad_valid_i.
- Ack delayed 4 cycles -> dc_req_o/adr/dat stable all 4 cycles; single pad_consume_o pulse and store_stall_o=0 in the ack cycle.
- SH adr 0x103 -> err_o pulse at cycle 1, dc_req_o never asserted, store_stall_o low from cycle 1.
- rst driven low during ISSUE -> dc_req_o, store_stall_o, pad_consume_o = 0 immediately; state is IDLE after release.

Source files
------------

// File: rtl/or1200_enc_store_xor_pkg.sv
// Shared definitions for the store-path encryption unit: LSU op codes,
// controller state encoding and the store alignment rule.
package or1200_enc_store_xor_pkg;

    // LSU store op encodings (mirrors or1200_defines.v)
    localparam logic [3:0] OR1200_LSUOP_SB = 4'b1010;
    localparam logic [3:0] OR1200_LSUOP_SH = 4'b1100;
    localparam logic [3:0] OR1200_LSUOP_SW = 4'b1110;

    // Store controller states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_PAD = 2'd1,
        ST_XOR      = 2'd2,
        ST_ISSUE    = 2'd3
    } enc_st_state_t;

    // A halfword must sit on an even address and a word on a 4-byte
    // boundary. Bytes and unknown ops never trap.
    function automatic logic is_misaligned(input logic [3:0] op,
                                           input logic [1:0] adr_lo);
        logic mis;
        mis = 1'b0;
        if ((op == OR1200_LSUOP_SH) && adr_lo[0])
            mis = 1'b1;
        if ((op == OR1200_LSUOP_SW) && (adr_lo != 2'b00))
            mis = 1'b1;
        return mis;
    endfunction

endpackage

// File: rtl/or1200_enc_store_xor_if.sv
// Bundle of the LSU store port, the store pad handshake and the dcache
// write port seen by the store encryption unit.
interface or1200_enc_store_xor_if #(
    parameter int DW    = 32,
    parameter int PAD_W = 128
);
    // LSU store request
    logic             st_req_i;
    logic [3:0]       st_op_i;
    logic [DW-1:0]    st_adr_i;
    logic [DW-1:0]    st_dat_i;
    logic [3:0]       st_sel_i;

    // Store pad from the encryption FSM
    logic             pad_valid_i;
    logic [PAD_W-1:0] pad_i;

    // dcache write port
    logic             dc_ack_i;
    logic             dc_req_o;
    logic [DW-1:0]    dc_adr_o;
    logic [DW-1:0]    dc_dat_o;
    logic [3:0]       dc_sel_o;

    // Status back to the pipeline and pad FSM
    logic             pad_consume_o;
    logic             store_stall_o;
    logic             err_o;

    // The encryption unit itself
    modport slave (
        input  st_req_i, st_op_i, st_adr_i, st_dat_i, st_sel_i,
        input  pad_valid_i, pad_i, dc_ack_i,
        output dc_req_o, dc_adr_o, dc_dat_o, dc_sel_o,
        output pad_consume_o, store_stall_o, err_o
    );

    // The surrounding LSU / pad FSM / dcache
    modport master (
        output st_req_i, st_op_i, st_adr_i, st_dat_i, st_sel_i,
        output pad_valid_i, pad_i, dc_ack_i,
        input  dc_req_o, dc_adr_o, dc_dat_o, dc_sel_o,
        input  pad_consume_o, store_stall_o, err_o
    );

endinterface

// File: rtl/or1200_enc_pad_align.sv
// Picks the 32-bit pad word addressed by adr[3:2] out of the 128-bit
// pad and rotates it right by whole bytes so that pad byte 0 of the
// access lines up with the lane the store data occupies.
module or1200_enc_pad_align #(
    parameter int PAD_W = 128,
    parameter int DW    = 32
) (
    input  logic [PAD_W-1:0] pad,
    input  logic [3:0]       adr,
    output logic [DW-1:0]    pad_aligned
);

    localparam int PAD_WORDS = PAD_W / DW;

    logic [DW-1:0] word;

    // Word select: word k lives in pad[DW*k +: DW]
    always_comb begin
        word = '0;
        for (int k = 0; k < PAD_WORDS; k++) begin
            if (adr[3:2] == 2'(k))
                word = pad[k*DW +: DW];
        end
    end

    // Byte rotate right by adr[1:0] bytes
    always_comb begin
        pad_aligned = word;
        case (adr[1:0])
            2'd0: pad_aligned = word;
            2'd1: pad_aligned = {word[7:0],  word[DW-1:8]};
            2'd2: pad_aligned = {word[15:0], word[DW-1:16]};
            2'd3: pad_aligned = {word[23:0], word[DW-1:24]};
            default: pad_aligned = word;
        endcase
    end

endmodule

// File: rtl/or1200_enc_store_xor.sv
// Store-path encryption unit. Latches an LSU store, waits for the store
// pad, XORs the aligned pad onto the enabled bytes and holds the dcache
// write request until it is acknowledged. The pipeline stays stalled for
// the whole operation.
module or1200_enc_store_xor
    import or1200_enc_store_xor_pkg::*;
#(
    parameter int PAD_W = 128,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    or1200_enc_store_xor_if.slave  bus
);

    enc_st_state_t state;
    enc_st_state_t state_nxt;

    logic [DW-1:0] adr_q;
    logic [DW-1:0] dat_q;
    logic [3:0]    sel_q;
    logic [DW-1:0] enc_q;
    logic          err_q;

    logic          accept;
    logic          misal;
    logic [DW-1:0] pad_al;
    logic [DW-1:0] enc_nxt;

    logic          dc_req;
    logic          pad_consume;
    logic          store_stall;

    // A held request in the cycle of its error pulse is the same store
    // that already trapped, so it is not taken a second time.
    assign accept = (state == ST_IDLE) && bus.st_req_i && !err_q;
    assign misal  = is_misaligned(bus.st_op_i, bus.st_adr_i[1:0]);

    or1200_enc_pad_align #(
        .PAD_W (PAD_W),
        .DW    (DW)
    ) u_pad_align (
        .pad         (bus.pad_i),
        .adr         (adr_q[3:0]),
        .pad_aligned (pad_al)
    );

    // Encrypt only the enabled byte lanes; the rest pass through
    always_comb begin
        enc_nxt = dat_q;
        for (int i = 0; i < 4; i++) begin
            if (sel_q[i])
                enc_nxt[8*i +: 8] = dat_q[8*i +: 8] ^ pad_al[8*i +: 8];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt   = state;
        dc_req      = 1'b0;
        pad_consume = 1'b0;
        store_stall = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    store_stall = 1'b1;
                    if (!misal)
                        state_nxt = bus.pad_valid_i ? ST_XOR : ST_WAIT_PAD;
                end
            end
            ST_WAIT_PAD: begin
                store_stall = 1'b1;
                if (bus.pad_valid_i)
                    state_nxt = ST_XOR;
            end
            ST_XOR: begin
                store_stall = 1'b1;
                state_nxt   = ST_ISSUE;
            end
            ST_ISSUE: begin
                dc_req = 1'b1;
                if (bus.dc_ack_i) begin
                    pad_consume = 1'b1;
                    state_nxt   = ST_IDLE;
                end else begin
                    store_stall = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Store capture on acceptance; held stable through ISSUE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            adr_q <= '0;
            dat_q <= '0;
            sel_q <= '0;
        end else if (accept) begin
            adr_q <= bus.st_adr_i;
            dat_q <= bus.st_dat_i;
            sel_q <= bus.st_sel_i;
        end
    end

    // Encrypted data register, loaded once in XOR so later pad changes
    // cannot disturb the write in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            enc_q <= '0;
        else if (state == ST_XOR)
            enc_q <= enc_nxt;
    end

    // Misalignment error pulse, one cycle after the offending request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_q <= 1'b0;
        else
            err_q <= accept && misal;
    end

    // The stall is gated by reset so that an LSU request held during
    // reset does not leak through the IDLE term.
    assign bus.dc_req_o      = dc_req;
    assign bus.pad_consume_o = pad_consume;
    assign bus.store_stall_o = store_stall && rst;
    assign bus.dc_adr_o      = adr_q;
    assign bus.dc_dat_o      = enc_q;
    assign bus.dc_sel_o      = sel_q;
    assign bus.err_o         = err_q;

endmodule

// File: tb/tb_or1200_enc_store_xor.sv
// Randomized bench for the store-path encryption unit with a reference
// model of the pad selection/rotation/XOR and of the cycle-level handshake.
module tb_or1200_enc_store_xor;

    localparam int DW    = 32;
    localparam int PAD_W = 128;

    localparam logic [3:0] OP_SB = 4'b1010;
    localparam logic [3:0] OP_SH = 4'b1100;
    localparam logic [3:0] OP_SW = 4'b1110;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    or1200_enc_store_xor_if #(.DW(DW), .PAD_W(PAD_W)) bus ();

    or1200_enc_store_xor #(.PAD_W(PAD_W), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: pick word adr/4 mod 4, rotate right by 8*(adr mod 4) bits
    // using 64-bit arithmetic, XOR into enabled bytes.
    function automatic logic [31:0] model_enc(input logic [127:0] pad, input logic [31:0] adr,
                                              input logic [31:0] dat, input logic [3:0] sel);
        logic [127:0]    shifted;
        longint unsigned w;
        longint unsigned rot;
        int              widx;
        int              sh;
        logic [31:0]     r32;
        logic [31:0]     res;
        widx    = int'((adr / 4) % 4);
        sh      = 8 * int'(adr % 4);
        shifted = pad >> (32 * widx);
        w       = longint'(shifted[31:0]);
        rot     = ((w >> sh) | (w << (32 - sh))) & 64'h0000_0000_ffff_ffff;
        r32     = rot[31:0];
        res     = dat;
        for (int i = 0; i < 4; i++)
            if (sel[i]) res[8*i +: 8] = dat[8*i +: 8] ^ r32[8*i +: 8];
        return res;
    endfunction

    function automatic bit model_misaligned(input logic [3:0] op, input logic [31:0] adr);
        if (op == OP_SH) return (adr % 2) != 0;
        if (op == OP_SW) return (adr % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] lane_sel(input logic [3:0] op, input logic [31:0] adr);
        if (op == OP_SB) return 4'b1000 >> (adr % 4);
        if (op == OP_SH) return ((adr % 4) < 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One store as the LSU sees it: request held until the stall drops.
    task automatic do_store(input logic [3:0] op, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input logic [127:0] pad,
                            input int pad_lat, input int ack_lat, input bit b2b);
        logic [31:0] exp_dat;
        next_cycle();
        bus.st_req_i    = 1'b1;
        bus.st_op_i     = op;
        bus.st_adr_i    = adr;
        bus.st_dat_i    = dat;
        bus.st_sel_i    = sel;
        bus.pad_i       = pad;
        bus.dc_ack_i    = 1'b0;
        bus.pad_valid_i = (pad_lat == 0);
        exp_dat = model_enc(pad, adr, dat, sel);
        @(negedge clk);
        chk("req_stall", bus.store_stall_o, 1);
        chk("req_dcreq", bus.dc_req_o, 0);

        if (model_misaligned(op, adr)) begin
            next_cycle();
            @(negedge clk);
            chk("err_pulse", bus.err_o, 1);
            chk("err_stall", bus.store_stall_o, 0);
            chk("err_dcreq", bus.dc_req_o, 0);
            next_cycle();
            bus.st_req_i = 1'b0;
            @(negedge clk);
            chk("err_clear", bus.err_o, 0);
            chk("err_dcreq2", bus.dc_req_o, 0);
            chk("err_stall2", bus.store_stall_o, 0);
            return;
        end

        for (int c = 1; c <= pad_lat; c++) begin
            next_cycle();
            bus.dc_ack_i = 1'($urandom_range(0, 1));
            if (c == pad_lat) bus.pad_valid_i = 1'b1;
            @(negedge clk);
            chk("wait_stall", bus.store_stall_o, 1);
            chk("wait_dcreq", bus.dc_req_o, 0);
            chk("wait_cons", bus.pad_consume_o, 0);
        end

        next_cycle();
        bus.dc_ack_i = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("xor_stall", bus.store_stall_o, 1);
        chk("xor_dcreq", bus.dc_req_o, 0);
        chk("xor_cons", bus.pad_consume_o, 0);

        for (int j = 0; j <= ack_lat; j++) begin
            next_cycle();
            bus.dc_ack_i    = (j == ack_lat);
            bus.pad_valid_i = 1'($urandom_range(0, 1));
            bus.pad_i       = {$urandom, $urandom, $urandom, $urandom};
            bus.st_adr_i    = $urandom;
            bus.st_dat_i    = $urandom;
            @(negedge clk);
            chk("iss_dcreq", bus.dc_req_o, 1);
            chk("iss_adr", bus.dc_adr_o, adr);
            chk("iss_dat", bus.dc_dat_o, exp_dat);
            chk("iss_sel", {28'd0, bus.dc_sel_o}, {28'd0, sel});
            chk("iss_stall", bus.store_stall_o, (j == ack_lat) ? 0 : 1);
            chk("iss_cons", bus.pad_consume_o, (j == ack_lat) ? 1 : 0);
            chk("iss_err", bus.err_o, 0);
        end

        if (!b2b) begin
            next_cycle();
            bus.st_req_i    = 1'b0;
            bus.dc_ack_i    = 1'b0;
            bus.pad_valid_i = 1'b0;
            @(negedge clk);
            chk("idle_stall", bus.store_stall_o, 0);
            chk("idle_dcreq", bus.dc_req_o, 0);
            chk("idle_cons", bus.pad_consume_o, 0);
        end
    endtask

    task automatic reset_mid_issue(input logic [127:0] pad);
        next_cycle();
        bus.st_req_i    = 1'b1;
        bus.st_op_i     = OP_SW;
        bus.st_adr_i    = 32'h0000_0200;
        bus.st_dat_i    = $urandom;
        bus.st_sel_i    = 4'hf;
        bus.pad_i       = pad;
        bus.pad_valid_i = 1'b1;
        bus.dc_ack_i    = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_pre_dcreq", bus.dc_req_o, 1);
        #2 rst = 1'b0;
        #1;
        chk("rst_dcreq", bus.dc_req_o, 0);
        chk("rst_stall", bus.store_stall_o, 0);
        chk("rst_cons", bus.pad_consume_o, 0);
        chk("rst_adr", bus.dc_adr_o, 0);
        chk("rst_dat", bus.dc_dat_o, 0);
        bus.st_req_i = 1'b0;
        next_cycle();
        chk("rst_hold_dcreq", bus.dc_req_o, 0);
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("post_rst_stall", bus.store_stall_o, 0);
        chk("post_rst_dcreq", bus.dc_req_o, 0);
    endtask

    initial begin
        logic [127:0] pad;
        logic [3:0]   op;
        logic [31:0]  adr;

        bus.st_req_i    = 1'b0;
        bus.st_op_i     = 4'd0;
        bus.st_adr_i    = '0;
        bus.st_dat_i    = '0;
        bus.st_sel_i    = 4'd0;
        bus.pad_valid_i = 1'b0;
        bus.pad_i       = '0;
        bus.dc_ack_i    = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_val_dcreq", bus.dc_req_o, 0);
        chk("rst_val_adr", bus.dc_adr_o, 0);
        chk("rst_val_dat", bus.dc_dat_o, 0);
        chk("rst_val_sel", {28'd0, bus.dc_sel_o}, 0);
        chk("rst_val_cons", bus.pad_consume_o, 0);
        chk("rst_val_stall", bus.store_stall_o, 0);
        chk("rst_val_err", bus.err_o, 0);
        rst = 1'b1;

        pad = 128'h0123456789abcdef0123456789abcdef;
        do_store(OP_SW, 32'h100, 32'hdeadbeef, 4'hf,    pad, 0, 0, 1'b0);
        do_store(OP_SB, 32'h105, 32'h00ab0000, 4'b0100, pad, 0, 0, 1'b0);
        do_store(OP_SW, 32'h108, 32'h12345678, 4'hf,    pad, 5, 0, 1'b0);
        do_store(OP_SH, 32'h10e, 32'h0000cafe, 4'b0011, pad, 1, 4, 1'b0);
        do_store(OP_SH, 32'h103, 32'h0000beef, 4'b0011, pad, 0, 0, 1'b0);
        do_store(OP_SW, 32'h204, 32'h0badf00d, 4'hf,    pad, 0, 1, 1'b1);
        do_store(OP_SB, 32'h20b, 32'h000000aa, 4'b0001, pad, 0, 0, 1'b0);
        reset_mid_issue(pad);
        do_store(OP_SW, 32'h300, 32'hdeadbeef, 4'hf,    pad, 0, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 2))
                0:       op = OP_SB;
                1:       op = OP_SH;
                default: op = OP_SW;
            endcase
            adr = $urandom;
            if ($urandom_range(0, 4) != 0) begin
                if (op == OP_SH) adr[0] = 1'b0;
                if (op == OP_SW) adr[1:0] = 2'b00;
            end
            pad = {$urandom, $urandom, $urandom, $urandom};
            do_store(op, adr, $urandom, lane_sel(op, adr), pad,
                     $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        next_cycle();
        bus.st_req_i = 1'b0;
        bus.dc_ack_i = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
